fetch_pc_unit: RTL

Parametrised fetch-address generator for the front end of the out-of-order core. It holds the fetch PC, issues one fetch-block request per cycle to the I-cache over a valid/ready handshake, and selects the next PC by priority: commit flush, execute redirect, predictor target, then sequential block. It also maintains a redirect epoch tag so that downstream stages can squash stale responses. Both flush and redirect also increment this tag.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_next_pc.sv | 56 +++++
 rtl/fetch_pc_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-block definitions: FSM states, default block geometry and the
// block-alignment helper reused by the decode stage for mask decoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_fsm_e;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned FETCH_WIDTH_DEF = 2;
  localparam int unsigned BLK_BYTES       = 4 * FETCH_WIDTH_DEF;
  localparam int unsigned OFF_W           = $clog2(BLK_BYTES);

  localparam logic [PC_W-1:0] BLK_OFF_MASK = PC_W'(BLK_BYTES - 1);

  function automatic logic [PC_W-1:0] block_align(input logic [PC_W-1:0] pc);
    return pc & ~BLK_OFF_MASK;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-fetch-PC selection: flush > redirect > predicted-taken > sequential block.
// Purely combinational so it can be shared with the predictor's lookahead.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_hs,
  input  logic            i_flush_valid,
  input  logic [XLEN-1:0] i_flush_pc,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_pred_valid,
  input  logic [XLEN-1:0] i_pred_pc,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_epoch_bump
);

  localparam int unsigned     LOC_BLK    = 4 * FETCH_WIDTH;
  localparam int unsigned     LOC_OFF_W  = $clog2(LOC_BLK);
  localparam logic [XLEN-1:0] W_BLK      = XLEN'(LOC_BLK);
  localparam logic [XLEN-1:0] W_OFF_MASK = XLEN'(LOC_BLK - 1);
  localparam logic [XLEN-1:0] W_WORD_MSK = ~(XLEN'(3));

  logic [XLEN-1:0] w_aligned;
  logic [XLEN-1:0] w_seq_pc;

  generate
    if (XLEN == PC_W && LOC_OFF_W == OFF_W) begin : g_pkg_align
      assign w_aligned = block_align(i_pc);
    end else begin : g_local_align
      assign w_aligned = i_pc & ~W_OFF_MASK;
    end
  endgenerate

  // Wraps to zero at the top of the address space by modulo arithmetic.
  assign w_seq_pc = w_aligned + W_BLK;

  always_comb begin
    o_next_pc = i_pc;
    if (i_flush_valid) begin
      o_next_pc = i_flush_pc & W_WORD_MSK;
    end else if (i_redirect_valid) begin
      o_next_pc = i_redirect_pc & W_WORD_MSK;
    end else if (i_hs && i_pred_valid) begin
      o_next_pc = i_pred_pc & W_WORD_MSK;
    end else if (i_hs) begin
      o_next_pc = w_seq_pc;
    end
  end

  assign o_epoch_bump = i_flush_valid || i_redirect_valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-address generator: holds the fetch PC, issues one block request per
// cycle over valid/ready, and tags requests with a redirect epoch.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   XLEN         = 32,
  parameter int unsigned   FETCH_WIDTH  = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned   EPOCH_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_valid,
  input  logic [XLEN-1:0]        flush_pc,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   pred_valid,
  input  logic [XLEN-1:0]        pred_pc,
  input  logic                   halt,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [XLEN-1:0]        req_pc,
  output logic [FETCH_WIDTH-1:0] req_mask,
  output logic [EPOCH_W-1:0]     req_epoch,
  output logic                   halted
);

  localparam int unsigned LOC_OFF_W = $clog2(4 * FETCH_WIDTH);
  localparam int unsigned SLOT_W    = (LOC_OFF_W > 2) ? LOC_OFF_W - 2 : 1;

  logic [XLEN-1:0]    r_pc;
  logic [EPOCH_W-1:0] r_epoch;
  fetch_fsm_e         r_fsm;

  fetch_fsm_e         w_fsm_nxt;
  logic [XLEN-1:0]    w_next_pc;
  logic               w_epoch_bump;
  logic               w_hs;

  assign req_valid = (r_fsm == RUN);
  assign req_pc    = r_pc;
  assign req_epoch = r_epoch;
  assign halted    = (r_fsm == HALTED);
  assign w_hs      = req_valid && req_ready;

  generate
    if (FETCH_WIDTH == 1) begin : g_mask_single
      assign req_mask = 1'b1;
    end else begin : g_mask_multi
      logic [SLOT_W-1:0] w_slot;
      assign w_slot = r_pc[LOC_OFF_W-1:2];
      // Slots before the entry word of an unaligned PC are not part of the fetch.
      always_comb begin
        req_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
          req_mask[i] = (SLOT_W'(i) >= w_slot);
        end
      end
    end
  endgenerate

  fetch_next_pc #(
    .XLEN        (XLEN),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_next_pc (
    .i_pc             (r_pc),
    .i_hs             (w_hs),
    .i_flush_valid    (flush_valid),
    .i_flush_pc       (flush_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_pred_valid     (pred_valid),
    .i_pred_pc        (pred_pc),
    .o_next_pc        (w_next_pc),
    .o_epoch_bump     (w_epoch_bump)
  );

  // Halt only takes effect once any presented request has been accepted.
  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      BOOT:    w_fsm_nxt = RUN;
      RUN:     if (halt && (w_hs || !req_valid)) w_fsm_nxt = HALTED;
      HALTED:  if (flush_valid || !halt) w_fsm_nxt = RUN;
      default: w_fsm_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_epoch <= '0;
      r_fsm   <= BOOT;
    end else begin
      r_pc  <= w_next_pc;
      r_fsm <= w_fsm_nxt;
      if (w_epoch_bump) begin
        r_epoch <= r_epoch + EPOCH_W'(1);
      end
    end
  end

endmodule
